sobel_line_buf: RTL and testbench

Row-buffering stage directly upstream of the 3x3 window-forming stage in the Sobel pipeline. It accepts a raster-order 8-bit grayscale stream, one pixel per accepted beat. For each beat it emits three vertically aligned pixels: the current row and the two rows above it. After the last input row it flushes one extra row of zero-padded "below" data, so the downstream window stage sees exactly ROWS*COLS output beats per frame.

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_line_buf_if.sv | 23 ++
 rtl/sobel_line_ram.sv | 26 ++
 rtl/sobel_line_buf.sv | 132 +++++++++++++
 tb/tb_sobel_line_buf.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line-buffer stage: geometry defaults,
// FSM state encoding and counter-width helper.
package sobel_pkg;

    localparam int unsigned DEF_COLS = 640;
    localparam int unsigned DEF_ROWS = 480;
    localparam int unsigned DEF_DW   = 8;

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_COL_W = cnt_width(DEF_COLS);
    localparam int unsigned DEF_ROW_W = cnt_width(DEF_ROWS);

endpackage

// File: rtl/sobel_line_buf_if.sv
// Pixel-in / three-tap-out stream bundle between the source and the line buffer.
interface sobel_line_buf_if #(
    parameter int unsigned DW = sobel_pkg::DEF_DW
);
    logic [DW-1:0] pix_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] d0_o;
    logic [DW-1:0] d1_o;
    logic [DW-1:0] d2_o;
    logic          done_o;
    logic          frame_done_o;

    modport slave (
        input  pix_i, valid_i,
        output ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o
    );

    modport master (
        output pix_i, valid_i,
        input  ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o
    );
endinterface

// File: rtl/sobel_line_ram.sv
// One row of pixel storage: registered read, read-before-write on address collision.
module sobel_line_ram #(
    parameter int unsigned DEPTH = sobel_pkg::DEF_COLS,
    parameter int unsigned WIDTH = sobel_pkg::DEF_DW,
    parameter int unsigned AW    = sobel_pkg::cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem[raddr_i];
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_line_buf.sv
// Two-line buffer feeding the 3x3 window stage: emits the current pixel plus the
// two pixels above it, then flushes one zero-padded row at the end of each frame.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    sobel_line_buf_if.slave        bus_io
);

    localparam int unsigned CW = cnt_width(COLS);
    localparam int unsigned RW = cnt_width(ROWS);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic [DW-1:0] d0_q;
    logic          d1_en_q, d2_en_q;
    logic          done_q, frame_done_q;
    logic          lb_we_q;
    logic [CW-1:0] lb_waddr_q;

    logic          flushing, beat, col_last, row_last;
    logic [DW-1:0] la_wdata, la_rdata, lb_rdata;

    always_comb begin
        flushing = (state_q == StFlush);
        beat     = flushing | bus_io.valid_i;
        col_last = (col_q == CW'(COLS - 1));
        row_last = (row_q == RW'(ROWS - 1));
        la_wdata = flushing ? '0 : bus_io.pix_i;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (beat) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            unique case (state_q)
                StFill: begin
                    if (col_last) begin
                        state_d = StRun;
                        row_d   = RW'(1);
                    end
                end
                StRun: begin
                    if (col_last) begin
                        if (row_last) state_d = StFlush;
                        else          row_d   = row_q + RW'(1);
                    end
                end
                StFlush: begin
                    if (col_last) begin
                        state_d = StFill;
                        row_d   = '0;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFill;
            col_q        <= '0;
            row_q        <= '0;
            d0_q         <= '0;
            d1_en_q      <= 1'b0;
            d2_en_q      <= 1'b0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            lb_we_q      <= 1'b0;
            lb_waddr_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            done_q       <= beat && (state_q != StFill);
            frame_done_q <= flushing && col_last;
            lb_we_q      <= beat;
            if (beat) begin
                d0_q       <= la_wdata;
                d1_en_q    <= (state_q != StFill);
                // LB holds nothing valid until row 2, so mask the top tap on row 1.
                d2_en_q    <= flushing || (state_q == StRun && row_q != RW'(1));
                lb_waddr_q <= col_q;
            end
        end
    end

    sobel_line_ram #(
        .DEPTH (COLS),
        .WIDTH (DW),
        .AW    (CW)
    ) u_la (
        .clk     (clk),
        .re_i    (beat),
        .raddr_i (col_q),
        .rdata_o (la_rdata),
        .we_i    (beat),
        .waddr_i (col_q),
        .wdata_i (la_wdata)
    );

    // LB takes LA's old word one cycle late, once the registered LA read has landed.
    sobel_line_ram #(
        .DEPTH (COLS),
        .WIDTH (DW),
        .AW    (CW)
    ) u_lb (
        .clk     (clk),
        .re_i    (beat),
        .raddr_i (col_q),
        .rdata_o (lb_rdata),
        .we_i    (lb_we_q),
        .waddr_i (lb_waddr_q),
        .wdata_i (la_rdata)
    );

    assign bus_io.ready_o      = !flushing;
    assign bus_io.d0_o         = d0_q;
    assign bus_io.d1_o         = d1_en_q ? la_rdata : '0;
    assign bus_io.d2_o         = d2_en_q ? lb_rdata : '0;
    assign bus_io.done_o       = done_q;
    assign bus_io.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_line_buf.sv
// Scoreboard bench for sobel_line_buf with a 4x3 frame and {row,col} pixel values.
module tb_sobel_line_buf;
    import sobel_pkg::*;

    localparam int unsigned COLS = 4;
    localparam int unsigned ROWS = 3;
    localparam int unsigned DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sobel_line_buf_if #(.DW(DW)) bus ();

    sobel_line_buf #(
        .COLS (COLS),
        .ROWS (ROWS),
        .DW   (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int n_done = 0, n_fd = 0, exp_done = 0, exp_fd = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] px(input int r, input int c, input logic [7:0] off);
        return 8'(r * 16 + c) + off;
    endfunction

    task automatic push_run(input int r, input int c, input logic [7:0] off);
        exp_t e;
        e.d0 = px(r, c, off);
        e.d1 = px(r - 1, c, off);
        e.d2 = (r == 1) ? 8'h00 : px(r - 2, c, off);
        e.fd = 1'b0;
        q.push_back(e);
        exp_done++;
    endtask

    task automatic push_flush(input logic [7:0] off);
        exp_t e;
        for (int c = 0; c < int'(COLS); c++) begin
            e.d0 = 8'h00;
            e.d1 = px(ROWS - 1, c, off);
            e.d2 = px(ROWS - 2, c, off);
            e.fd = (c == int'(COLS) - 1);
            q.push_back(e);
            exp_done++;
            if (e.fd) exp_fd++;
        end
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done_o) begin
                n_done++;
                if (bus.frame_done_o) n_fd++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got d0=%0h d1=%0h d2=%0h want no beat",
                             bus.d0_o, bus.d1_o, bus.d2_o);
                end else begin
                    e = q.pop_front();
                    check("d0", bus.d0_o, e.d0);
                    check("d1", bus.d1_o, e.d1);
                    check("d2", bus.d2_o, e.d2);
                    check("frame_done", bus.frame_done_o, e.fd);
                end
            end else begin
                check("frame_done_without_done", bus.frame_done_o, 0);
            end
        end
    end

    // Called #1 after a clock edge; returns #1 after the edge that accepted the pixel.
    task automatic send(input logic [7:0] p, input bit gaps);
        logic rdy;
        int   waits;
        if (gaps) begin
            bus.valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.pix_i   = p;
        bus.valid_i = 1'b1;
        waits = 0;
        do begin
            rdy = bus.ready_o;
            @(posedge clk);
            #1;
            waits++;
        end while (!rdy && waits < 20);
        check("accept_ready", rdy, 1);
    endtask

    task automatic send_rows(input logic [7:0] off, input bit gaps);
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++) begin
                if (r >= 1) push_run(r, c, off);
                send(px(r, c, off), gaps);
            end
        push_flush(off);
    endtask

    // Flush phase with valid_i held high on junk data, which must be ignored.
    task automatic flush_phase();
        bus.pix_i   = 8'hEE;
        bus.valid_i = 1'b1;
        for (int i = 0; i < int'(COLS); i++) begin
            check("flush_ready_low", bus.ready_o, 0);
            @(posedge clk);
            #1;
        end
        check("ready_after_flush", bus.ready_o, 1);
        bus.valid_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_d0"}, bus.d0_o, 0);
        check({tag, "_d1"}, bus.d1_o, 0);
        check({tag, "_d2"}, bus.d2_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_frame_done"}, bus.frame_done_o, 0);
    endtask

    // Asserts reset between edges, checks outputs clear at once, drops stale expectations.
    task automatic reset_pulse(input string tag);
        exp_t e;
        rst = 1'b1;
        #1;
        check_outputs_zero(tag);
        while (q.size() > 0) begin
            e = q.pop_front();
            exp_done--;
            if (e.fd) exp_fd--;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ready"}, bus.ready_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done, base_fd;
        bus.pix_i   = '0;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.ready_o, 1);

        // Frame 1: back-to-back.
        base_done = n_done;
        base_fd   = n_fd;
        send_rows(8'h00, 1'b0);
        flush_phase();
        @(posedge clk);
        #1;
        check("frame1_done_count", n_done - base_done, 12);
        check("frame1_fd_count", n_fd - base_fd, 1);

        // Frame 2: same data with random input gaps.
        base_done = n_done;
        send_rows(8'h00, 1'b1);
        flush_phase();
        @(posedge clk);
        #1;
        check("frame2_done_count", n_done - base_done, 12);

        // Reset mid row 1.
        for (int c = 0; c < int'(COLS); c++) send(px(0, c, 8'h00), 1'b0);
        push_run(1, 0, 8'h00);
        send(px(1, 0, 8'h00), 1'b0);
        push_run(1, 1, 8'h00);
        send(px(1, 1, 8'h00), 1'b0);
        bus.valid_i = 1'b0;
        #6;
        reset_pulse("rst_row1");

        // Reset mid flush.
        send_rows(8'h00, 1'b0);
        bus.valid_i = 1'b0;
        @(posedge clk);
        #6;
        reset_pulse("rst_flush");

        // Clean frame with new data after reset; row-1 d2 must be masked.
        send_rows(8'h80, 1'b1);
        flush_phase();

        // Two frames with no idle between them.
        send_rows(8'h40, 1'b0);
        flush_phase();
        send_rows(8'h00, 1'b0);
        flush_phase();

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);
        check("total_done_count", n_done, exp_done);
        check("total_fd_count", n_fd, exp_fd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
